// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: bubble word, reset PC default,
// FSM state encoding and the sequential PC increment helper.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'h0000_0004;

    // FETCH: requesting from instruction memory.
    // HOLD : one fetched word parked in the buffer, no request.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    // Sequential next PC; wraps naturally modulo 2^32.
    function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with synchronous reset, redirect load and
// sequential increment (priority: reset > load > increment > hold).
module fetch_stage_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        inc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc_next_seq(pc);

    // PC update: reset, branch redirect, or advance past a consumed fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc_plus4;
        end else begin
            pc <= pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives instruction memory from the PC, fills the
// IF/ID register, parks one word when decode stalls, and handles redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        imem_en,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_wait,
    output logic [31:0] Instr,
    output logic [31:0] IFIDPC4,
    output logic        IFIDValid
);

    fetch_state_e state_r;
    fetch_state_e state_next_s;
    logic [31:0]  pc_s;
    logic [31:0]  pc_plus4_s;
    logic [31:0]  buf_instr_r;
    logic [31:0]  buf_pc4_r;
    logic         fire_s;
    logic         pc_load_s;
    logic         pc_inc_s;

    assign imem_req  = (state_r == FETCH) & enable & imem_en & ~BranchTaken & ~rst;
    assign fire_s    = imem_req & ~imem_wait;
    assign imem_addr = pc_s;

    // The PC only moves when a completed fetch is actually consumed (IF/ID or buffer).
    assign pc_load_s = enable & BranchTaken;
    assign pc_inc_s  = enable & ~BranchTaken & fire_s & PCWrite;

    fetch_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load_s),
        .load_val (BranchTarget),
        .inc      (pc_inc_s),
        .pc       (pc_s),
        .pc_plus4 (pc_plus4_s)
    );

    // Next-state logic: park on a fetch that decode cannot accept, drain when it can.
    always_comb begin
        state_next_s = state_r;
        if (!enable) begin
            state_next_s = state_r;
        end else if (BranchTaken) begin
            state_next_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    if (fire_s && PCWrite && !IFIDWrite) begin
                        state_next_s = HOLD;
                    end else begin
                        state_next_s = FETCH;
                    end
                end
                HOLD: begin
                    if (IFIDWrite) begin
                        state_next_s = FETCH;
                    end else begin
                        state_next_s = HOLD;
                    end
                end
                default: state_next_s = FETCH;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // IF/ID register and one-entry skid buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            Instr       <= NOP_INSTR;
            IFIDPC4     <= 32'h0000_0000;
            IFIDValid   <= 1'b0;
            buf_instr_r <= 32'h0000_0000;
            buf_pc4_r   <= 32'h0000_0000;
        end else if (!enable) begin
            Instr       <= Instr;
            IFIDPC4     <= IFIDPC4;
            IFIDValid   <= IFIDValid;
            buf_instr_r <= buf_instr_r;
            buf_pc4_r   <= buf_pc4_r;
        end else if (BranchTaken) begin
            // Flush: bubble into decode, drop anything parked or arriving.
            Instr       <= NOP_INSTR;
            IFIDValid   <= 1'b0;
            buf_instr_r <= 32'h0000_0000;
            buf_pc4_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                FETCH: begin
                    if (!PCWrite && IFIDWrite) begin
                        // Branch sitting in decode: insert a bubble, the fetched word is refetched.
                        Instr     <= NOP_INSTR;
                        IFIDValid <= 1'b0;
                    end else if (fire_s && PCWrite && IFIDWrite) begin
                        Instr     <= imem_rdata;
                        IFIDPC4   <= pc_plus4_s;
                        IFIDValid <= 1'b1;
                    end else if (fire_s && PCWrite) begin
                        buf_instr_r <= imem_rdata;
                        buf_pc4_r   <= pc_plus4_s;
                    end else begin
                        Instr <= Instr;
                    end
                end
                HOLD: begin
                    if (IFIDWrite) begin
                        Instr     <= buf_instr_r;
                        IFIDPC4   <= buf_pc4_r;
                        IFIDValid <= 1'b1;
                    end else begin
                        Instr <= Instr;
                    end
                end
                default: begin
                    Instr <= Instr;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, enable, PCWrite, IFIDWrite, imem_en, BranchTaken, imem_wait;
    logic [31:0] BranchTarget, imem_rdata;
    logic [31:0] imem_addr, Instr, IFIDPC4;
    logic        imem_req, IFIDValid;

    int total = 0;
    int bad   = 0;

    // Reference model: PC, IF/ID contents and a queue of parked words.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic        m_known = 1'b0;
    logic [63:0] m_buf[$];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .enable(enable), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .imem_en(imem_en), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_wait(imem_wait), .Instr(Instr),
        .IFIDPC4(IFIDPC4), .IFIDValid(IFIDValid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic pcw, input logic ifw,
                         input logic ie, input logic bt, input logic [31:0] tgt,
                         input logic wt, input logic [31:0] rd);
        rst = r; enable = en; PCWrite = pcw; IFIDWrite = ifw; imem_en = ie;
        BranchTaken = bt; BranchTarget = tgt; imem_wait = wt; imem_rdata = rd;
    endtask

    // Apply one clock edge to the model, straight from the behavioural rules.
    task automatic model_edge();
        logic [63:0] e;
        if (rst) begin
            m_pc = RST_PC; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
            m_buf.delete(); m_known = 1'b1;
        end else if (!enable) begin
            m_pc = m_pc;
        end else if (BranchTaken) begin
            m_pc = BranchTarget; m_instr = NOP; m_valid = 1'b0; m_buf.delete();
        end else if (m_buf.size() == 0) begin
            if (!PCWrite && IFIDWrite) begin
                m_instr = NOP; m_valid = 1'b0;
            end else if (imem_en && !imem_wait && PCWrite) begin
                if (IFIDWrite) begin
                    m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                end else begin
                    m_buf.push_back({imem_rdata, m_pc + 32'd4});
                end
                m_pc = m_pc + 32'd4;
            end
        end else if (IFIDWrite) begin
            e = m_buf.pop_front();
            m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1'b1;
        end
    endtask

    // One cycle: check combinational outputs, clock, update model, check registers.
    task automatic cycle();
        logic exp_req;
        #1;
        exp_req = (m_buf.size() == 0) && enable && imem_en && !BranchTaken && !rst;
        if (rst) chk("req_in_rst", {31'b0, imem_req}, 32'h0);
        else if (m_known) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            chk("imem_addr", imem_addr, m_pc);
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("Instr", Instr, m_instr);
        chk("IFIDPC4", IFIDPC4, m_pc4);
        chk("IFIDValid", {31'b0, IFIDValid}, {31'b0, m_valid});
        chk("pc", imem_addr, m_pc);
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        cycle();
        chk("rst_valid", {31'b0, IFIDValid}, 32'h0);
        chk("rst_instr", Instr, NOP);

        // First fetch out of reset.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8C01_0004);
        #1 chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        cycle();
        chk("first_instr", Instr, 32'h8C01_0004);
        chk("first_pc4", IFIDPC4, 32'h4);
        chk("first_pc", imem_addr, 32'h4);
        imem_rdata = 32'h1111_1111;
        cycle();

        // Memory wait for three cycles at PC=8.
        imem_wait = 1'b1; imem_rdata = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("wait_pc", imem_addr, 32'h8);
            chk("wait_instr", Instr, 32'h1111_1111);
        end
        imem_wait = 1'b0;
        cycle();
        chk("wait_done_pc", imem_addr, 32'hC);
        chk("wait_done_instr", Instr, 32'h2222_2222);
        imem_rdata = 32'h3333_3333;
        cycle();

        // Decode stall at PC=16: word parks in the buffer.
        IFIDWrite = 1'b0; imem_rdata = 32'h0022_1820;
        cycle();
        chk("hold_pc", imem_addr, 32'h14);
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        IFIDWrite = 1'b1;
        cycle();
        chk("drain_instr", Instr, 32'h0022_1820);
        chk("drain_pc4", IFIDPC4, 32'h14);

        // Branch while holding a buffered word.
        IFIDWrite = 1'b0; imem_rdata = 32'h4444_4444;
        cycle();
        BranchTaken = 1'b1; BranchTarget = 32'h0000_0100; IFIDWrite = 1'b1;
        cycle();
        chk("br_instr", Instr, NOP);
        chk("br_valid", {31'b0, IFIDValid}, 32'h0);
        chk("br_pc", imem_addr, 32'h100);
        BranchTaken = 1'b0;
        #1 chk("br_req", {31'b0, imem_req}, 32'h1);

        // PC wrap, then reset during a frozen stall.
        BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        cycle();
        BranchTaken = 1'b0; imem_rdata = 32'h5555_5555;
        cycle();
        chk("wrap_pc", imem_addr, 32'h0);
        chk("wrap_pc4", IFIDPC4, 32'h0);
        imem_wait = 1'b1;
        cycle();
        enable = 1'b0; rst = 1'b1;
        cycle();
        chk("rst_stall_pc", imem_addr, RST_PC);
        chk("rst_stall_valid", {31'b0, IFIDValid}, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                  $urandom(), ($urandom_range(0, 3) == 0), $urandom());
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
